// File: rtl/spi_pkg.sv
// Shared types for the SPI slave front-end.
//   state_e : controller FSM states
//   cmd_e   : two-bit command field carried at the top of every payload
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

endpackage

// File: rtl/miso_serializer.sv
// Parallel-to-serial MISO driver for RAM read data.
//   clk, rst_n : clock, async active-low reset
//   clear      : abandon any shift-out in progress, force MISO low
//   load       : capture data; MSB appears on MISO after the following edge
//   data       : DATA_W-bit word to send, MSB first
//   miso       : registered serial output, 0 when idle
//   done       : high during the cycle whose edge shifts out the LSB
module miso_serializer #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  output logic              miso,
  output logic              done
);

  localparam int unsigned CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(DATA_W - 1);

  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              active_q, active_d;
  logic              miso_q, miso_d;

  always_comb begin
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    miso_d   = 1'b0;
    done     = 1'b0;
    if (clear) begin
      active_d = 1'b0;
      cnt_d    = '0;
    end else if (active_q) begin
      miso_d  = shreg_q[DATA_W-1];
      shreg_d = shreg_q << 1;
      if (cnt_q == LastCnt) begin
        active_d = 1'b0;
        cnt_d    = '0;
        done     = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (load) begin
      shreg_d  = data;
      active_d = 1'b1;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q  <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      miso_q   <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      miso_q   <= miso_d;
    end
  end

  assign miso = miso_q;

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end for the single-port RAM. clk doubles as the SPI bit clock.
//   clk, rst_n : clock, async active-low reset
//   SS_n       : slave select, active low
//   MOSI       : serial in; select bit then DATA_W+2 payload bits, MSB first
//   MISO       : serial read data out, MSB first, registered
//   rx_data    : {cmd, payload} to RAM din, held between strobes
//   rx_valid   : one-cycle strobe for rx_data
//   tx_data    : RAM dout
//   tx_valid   : RAM read data valid, only honoured while awaiting read data
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);

  localparam int unsigned FW  = DATA_W + 2;
  localparam int unsigned PCW = $clog2(FW);
  localparam logic [PCW-1:0] LastBit = PCW'(FW - 1);

  state_e          state_q, state_d;
  logic [PCW-1:0]  pcnt_q, pcnt_d;
  logic [FW-2:0]   shreg_q, shreg_d;   // the final bit goes straight into rx_data
  logic [FW-1:0]   rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rd_addr_seen_q, rd_addr_seen_d;
  logic            frame_done_q, frame_done_d;  // payload complete, ignore MOSI until SS_n
  logic            await_q, await_d;            // READ_DATA waiting for tx_valid
  logic            ser_load, ser_clear, ser_done;

  always_comb begin
    state_d        = state_q;
    pcnt_d         = pcnt_q;
    shreg_d        = shreg_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_seen_d = rd_addr_seen_q;
    frame_done_d   = frame_done_q;
    await_d        = await_q;
    ser_load       = 1'b0;
    ser_clear      = 1'b0;

    unique case (state_q)
      IDLE: begin
        pcnt_d       = '0;
        frame_done_d = 1'b0;
        await_d      = 1'b0;
        ser_clear    = 1'b1;
        if (!SS_n) state_d = CHK_CMD;
      end
      CHK_CMD: begin
        if (SS_n)                state_d = IDLE;
        else if (!MOSI)          state_d = WRITE;
        else if (!rd_addr_seen_q) state_d = READ_ADD;
        else                     state_d = READ_DATA;
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (!frame_done_q) begin
          shreg_d = {shreg_q[FW-3:0], MOSI};
          // Last bit wins over a simultaneous SS_n rise: the frame is complete.
          if (pcnt_q == LastBit) begin
            pcnt_d       = '0;
            rx_valid_d   = 1'b1;
            rx_data_d    = {shreg_q, MOSI};
            frame_done_d = 1'b1;
            if (state_q == READ_ADD)  rd_addr_seen_d = 1'b1;
            if (state_q == READ_DATA) await_d = 1'b1;
            if (SS_n) state_d = IDLE;
          end else if (SS_n) begin
            pcnt_d  = '0;
            state_d = IDLE;
          end else begin
            pcnt_d = pcnt_q + 1'b1;
          end
        end else if (SS_n) begin
          ser_clear    = 1'b1;
          await_d      = 1'b0;
          frame_done_d = 1'b0;
          state_d      = IDLE;
        end else if (await_q && tx_valid) begin
          ser_load = 1'b1;
          await_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Only a completed shift-out retires the read address; an aborted one keeps it.
    if (ser_done) rd_addr_seen_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      pcnt_q         <= '0;
      shreg_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_seen_q <= 1'b0;
      frame_done_q   <= 1'b0;
      await_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      pcnt_q         <= pcnt_d;
      shreg_q        <= shreg_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_seen_q <= rd_addr_seen_d;
      frame_done_q   <= frame_done_d;
      await_q        <= await_d;
    end
  end

  miso_serializer #(
    .DATA_W (DATA_W)
  ) u_miso_serializer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (ser_clear),
    .load  (ser_load),
    .data  (tx_data),
    .miso  (MISO),
    .done  (ser_done)
  );

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: doc/spi_slave_ctrl.md
# spi_slave_ctrl

SPI slave front-end that converts a serial MOSI frame into a parallel command word for the single-port RAM, and serializes RAM read data back onto MISO. It drives the RAM's `din`/`rx_valid` input side and consumes its `dout`/`tx_valid` output side. It forms the serial half of the SPI wrapper, with `clk` used directly as the SPI bit clock.

## Interface
One clock; reset is asynchronous and active-low (`clk`, `rst_n`).

Parameters:
- `DATA_W`, default 8: RAM data/address width. The frame payload is `DATA_W+2` bits.

Ports:
- `clk` in 1: system clock, also the SPI bit clock; MOSI and SS_n are sampled on its rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `SS_n` in 1: slave select, active-low; frames only while low.
- `MOSI` in 1: serial data in, MSB first.
- `MISO` out 1: serial read data out, MSB first, registered.
- `rx_data` out DATA_W+2: {cmd[1:0], payload[DATA_W-1:0]} to RAM `din`.
- `rx_valid` out 1: one-cycle strobe; `rx_data` is valid.
- `tx_data` in DATA_W: RAM `dout`.
- `tx_valid` in 1: RAM read data valid; sampled only while awaiting read data.

## Operation
- **Frame format:**
  - SS_n falls.
  - 1 select bit: 0 = write, 1 = read.
  - DATA_W+2 payload bits, MSB first.
- **Command encodings (`cmd`):** 00 write address, 01 write data, 10 read address, 11 read data. `cmd` is forwarded unchecked, even if it disagrees with the select bit.
- **States:** IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
  - IDLE: SS_n=0 → CHK_CMD.
  - CHK_CMD: SS_n=1 → IDLE. MOSI=0 → WRITE. MOSI=1 and `rd_addr_seen`=0 → READ_ADD. MOSI=1 and `rd_addr_seen`=1 → READ_DATA.
  - WRITE / READ_ADD / READ_DATA: shift MOSI into the shift register for DATA_W+2 cycles, then pulse `rx_valid` with the assembled word.
  - Any state with SS_n=1 → IDLE. Bit counters clear and any partially shifted frame is discarded with no `rx_valid`.
- **`rd_addr_seen` flag:**
  - Set on `rx_valid` in READ_ADD.
  - Cleared when READ_DATA finishes shifting out all DATA_W bits.
  - A READ_DATA frame aborted by SS_n before that point leaves it set.
- **READ_DATA tail:**
  - After `rx_valid`, wait (unbounded) for `tx_valid`=1 and capture `tx_data`.
  - Then drive DATA_W bits on MISO, MSB first, one per cycle.
  - Afterwards MISO=0; remain in READ_DATA until SS_n=1.
- **Ignored inputs:** `tx_valid` is ignored in every other state and phase. A second `tx_valid` during shift-out is ignored.
- **Counters:** payload counter is $clog2(DATA_W+2) bits (4 for default); wraps to 0 on frame end or abort. Output bit counter is $clog2(DATA_W) bits (3 for default).

## Timing
- **Reset values:** MISO=0, `rx_valid`=0, `rx_data`=0, state IDLE, `rd_addr_seen`=0, all counters 0.
- **Reset mid-frame:** returns to the reset values immediately (asynchronous), with no `rx_valid` pulse.
- **Frame cycles:**
  - Cycle 0: SS_n sampled low → CHK_CMD next.
  - Cycle 1: select bit sampled.
  - Cycles 2..DATA_W+3: payload bits.
- **`rx_valid`:** high exactly one cycle, in the cycle after the last payload bit is sampled (cycle DATA_W+4 = 12 for default). `rx_data` updates in that same cycle and is held until the next `rx_valid`.
- **MISO latency:** `tx_valid` sampled high at edge N puts the MSB on MISO after edge N+1. The LSB is held through edge N+DATA_W. MISO=0 after edge N+DATA_W+1.
- **SS_n rising with `rx_valid`:** if SS_n rises on the same edge the last payload bit is sampled, the frame is complete and `rx_valid` still pulses.

## Structure
- Package `spi_pkg`:
  - `state_e` enum (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA).
  - `cmd_e` constants: CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
- Sub-module `miso_serializer`:
  - Inputs: load strobe, DATA_W data.
  - Output: MISO, plus a `done` pulse used to clear `rd_addr_seen`.
  - The FSM and input shift register stay in `spi_slave_ctrl`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-WRITE frame → MISO=0, `rx_valid`=0, `rx_data`=0 immediately; next frame decodes correctly.
- **Write address:** SS_n=0, select 0, payload 10'b00_1010_0101 → one-cycle `rx_valid` at cycle 12 with `rx_data`=10'h0A5, state WRITE.
- **Read sequence:**
  - Frame 1: select 1, payload 10'b10_0000_0011 → `rx_data`=10'h203 in READ_ADD, `rd_addr_seen`=1.
  - Frame 2: select 1, payload 10'h300 → READ_DATA, `rx_valid` with `rx_data`=10'h300.
  - Drive `tx_valid` with `tx_data`=8'hC3 → MISO = 1,1,0,0,0,0,1,1 from the next cycle, then 0; `rd_addr_seen`=0.
- **Abort:** SS_n high after 5 payload bits → IDLE, no `rx_valid`. A following full frame yields the correct word, with the bit counter restarted.
- **Stray `tx_valid`:** pulse `tx_valid` during WRITE and while in IDLE → MISO stays 0 and no state change.
- **Aborted read data:** SS_n high during shift-out → `rd_addr_seen` stays 1 and the next read frame enters READ_DATA.
